// File: rtl/seq_divider_pkg.sv
// Shared types for the iterative restoring divider: FSM state encoding and counter sizing.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT     = 32;
    localparam int CNT_W_DEFAULT = $clog2(N_DEFAULT);

    // Counter must hold N-1; N >= 2 keeps this at least one bit wide.
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; the caller registers the partial remainder.
module divider_step #(
    parameter int N = 32
) (
    input  logic [N:0]   prem,
    input  logic [N-1:0] divisor,
    input  logic         bit_in,
    output logic [N:0]   prem_nxt,
    output logic         qbit
);

    // One bit of headroom above the partial remainder so the shifted value can never wrap.
    logic [N+1:0] shifted;
    logic [N+1:0] dvsr_ext;

    always_comb begin
        shifted  = {prem, bit_in};
        dvsr_ext = {2'b00, divisor};
        qbit     = (shifted >= dvsr_ext);
        prem_nxt = qbit ? (N+1)'(shifted - dvsr_ext) : shifted[N:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock; result valid N edges after accept.
// Optional two's-complement mode when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [N:0]     prem;
    logic [N:0]     prem_nxt;
    logic [N-1:0]   shreg;
    logic [N-1:0]   dvsr;
    logic           qbit;
    logic [N-1:0]   quot_q, rem_q;
    logic           dbz_q;
    logic [N-1:0]   a_mag, b_mag;
    logic [N-1:0]   quot_mag, rem_mag;
    logic [N-1:0]   quot_fin, rem_fin;

    divider_step #(.N(N)) u_step (
        .prem     (prem),
        .divisor  (dvsr),
        .bit_in   (shreg[N-1]),
        .prem_nxt (prem_nxt),
        .qbit     (qbit)
    );

    assign quot_mag = {shreg[N-2:0], qbit};
    assign rem_mag  = prem_nxt[N-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_a, neg_b;

    assign a_mag = dividend[N-1] ? -dividend : dividend;
    assign b_mag = divisor[N-1]  ? -divisor  : divisor;

    // Zero divisor keeps the raw all-ones quotient; remainder sign follows the dividend.
    always_comb begin
        quot_fin = quot_mag;
        rem_fin  = neg_a ? -rem_mag : rem_mag;
        if ((dvsr != '0) && (neg_a ^ neg_b))
            quot_fin = -quot_mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_a <= 1'b0;
            neg_b <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            neg_a <= dividend[N-1];
            neg_b <= divisor[N-1];
        end
    end
`else
    assign a_mag    = dividend;
    assign b_mag    = divisor;
    assign quot_fin = quot_mag;
    assign rem_fin  = rem_mag;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = BUSY;
            BUSY:    if (cnt == '0)  state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            prem   <= '0;
            shreg  <= '0;
            dvsr   <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt   <= CW'(N - 1);
                        prem  <= '0;
                        shreg <= a_mag;
                        dvsr  <= b_mag;
                    end
                end
                BUSY: begin
                    cnt   <= cnt - 1'b1;
                    prem  <= prem_nxt;
                    shreg <= quot_mag;
                    // Final iteration publishes the sign-corrected result directly.
                    if (cnt == '0) begin
                        quot_q <= quot_fin;
                        rem_q  <= rem_fin;
                        dbz_q  <= (dvsr == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed checks of seq_divider against a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int N   = 32;
    localparam int LAT = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  quotient;
    logic [N-1:0]  remainder;
    logic          div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] q, output logic [N-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Issue one operation, hold out_ready low for 'stall' cycles in DONE, then retire it.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input logic edbz);
        int lat;
        @(negedge clk);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = 0;
        while (!out_valid && lat < 4 * LAT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(LAT));
        if (!out_valid) return;
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        check("valid_held", 64'(out_valid), 64'd1);
        check("in_ready_in_done", 64'(in_ready), 64'd0);
        check("quotient", 64'(quotient), 64'(eq));
        check("remainder", 64'(remainder), 64'(er));
        check("div_by_zero", 64'(div_by_zero), 64'(edbz));
`ifndef SEQ_DIVIDER_SIGNED_EN
        if (b != '0) begin
            check("q_times_d_plus_r", 64'(quotient) * 64'(b) + 64'(remainder), 64'(a));
            check("r_lt_d", 64'(remainder < b), 64'd1);
        end
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [N-1:0] a, b, q, r;
        int sel;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(32'd100, 32'd7, 0, 32'd14, 32'd2, 1'b0);
        do_op(32'hFFFF_FFFF, 32'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op(32'd1000, 32'd10, 5, 32'd100, 32'd0, 1'b0);
        do_op(32'd5, 32'd9, 0, 32'd0, 32'd5, 1'b0);

        // Reset during BUSY once the counter has stepped down to 10.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 32'd1234;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("midop_rst_out_valid", 64'(out_valid), 64'd0);
        check("midop_rst_in_ready", 64'(in_ready), 64'd1);
        check("midop_rst_quotient", 64'(quotient), 64'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        do_op(32'd81, 32'd9, 0, 32'd9, 32'd0, 1'b0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        do_op(-32'sd7, 32'd2, 0, -32'sd3, -32'sd1, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0, 1'b0);
        do_op(32'd7, -32'sd2, 0, -32'sd3, 32'd1, 1'b0);
        do_op(-32'sd9, 32'd0, 0, 32'hFFFF_FFFF, -32'sd9, 1'b1);
`endif

        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            case (sel)
                0:       b = '0;
                1, 2:    b = N'($urandom_range(1, 15));
                3:       b = a + N'($urandom_range(1, 100));
                4:       b = N'($urandom_range(1, 65535));
                default: b = $urandom;
            endcase
            if (sel == 9) a = N'($urandom_range(0, 255));
            model(a, b, q, r);
            do_op(a, b, $urandom_range(0, 3), q, r, (b == '0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
